// File: rtl/dlx_seq_ctrl.sv
// ============================================================================
// dlx_seq_ctrl : multi-cycle DLX sequencer (IF/ID/EX/BR/MEM/WB) with retire counter
// Revision 1.0
// ============================================================================
`default_nettype none

module dlx_seq_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [31:0]      ir,
    input  logic             Zflag,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             link,
    output logic             s1_sel,
    output logic [4:0]       ALUop,
    output logic [2:0]       s2op,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_PASS = 5'b00010;

    localparam logic [2:0] S2_REG   = 3'b000;
    localparam logic [2:0] S2_IMM16 = 3'b011;
    localparam logic [2:0] S2_IMM26 = 3'b101;
    localparam logic [2:0] S2_FOUR  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_BR   = 3'd4,
        S_MEM  = 3'd5,
        S_WB   = 3'd6
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [5:0] opcode;
    logic       is_lw;
    logic       is_sw;
    logic       is_jal;
    logic       taken;
    logic       retire;
    logic       unused_ir_bits;

    assign opcode         = ir[31:26];
    assign is_lw          = (opcode == OP_LW);
    assign is_sw          = (opcode == OP_SW);
    assign is_jal         = (opcode == OP_JAL);
    assign taken          = ((opcode == OP_BEQZ) &&  Zflag) ||
                            ((opcode == OP_BNEZ) && !Zflag);
    assign unused_ir_bits = ^ir[25:5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        wb_sel     = 1'b0;
        link       = 1'b0;
        s1_sel     = 1'b0;
        ALUop      = ALU_ADD;
        s2op       = S2_REG;
        illegal    = 1'b0;

        case (state)
            S_IDLE: begin
                if (go) begin
                    next_state = S_IF;
                end
            end
            S_IF: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    next_state = S_ID;
                end
            end
            S_ID: begin
                // PC <= PC + 4 here, so later branch/jump offsets are PC+4 relative
                s1_sel     = 1'b1;
                s2op       = S2_FOUR;
                pc_we      = 1'b1;
                next_state = S_EX;
            end
            S_EX: begin
                case (opcode)
                    OP_RTYPE: begin
                        ALUop      = ir[4:0];
                        next_state = S_WB;
                    end
                    OP_ADDI: begin
                        s2op       = S2_IMM16;
                        next_state = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        s2op       = S2_IMM16;
                        next_state = S_MEM;
                    end
                    OP_BEQZ, OP_BNEZ: begin
                        ALUop = ALU_PASS;
                        if (taken) begin
                            next_state = S_BR;
                        end else begin
                            retire = 1'b1;
                        end
                    end
                    OP_J: begin
                        s1_sel = 1'b1;
                        s2op   = S2_IMM26;
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                    OP_JAL: begin
                        // Return address (already PC+4) passes through the ALU into r31
                        s1_sel     = 1'b1;
                        ALUop      = ALU_PASS;
                        reg_we     = 1'b1;
                        link       = 1'b1;
                        next_state = S_BR;
                    end
                    default: begin
                        illegal = 1'b1;
                        retire  = 1'b1;
                    end
                endcase
            end
            S_BR: begin
                s1_sel = 1'b1;
                pc_we  = 1'b1;
                s2op   = is_jal ? S2_IMM26 : S2_IMM16;
                retire = 1'b1;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_sw;
                s2op     = S2_IMM16;
                if (mem_ready) begin
                    if (is_sw) begin
                        retire = 1'b1;
                    end else begin
                        next_state = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                wb_sel = is_lw;
                retire = 1'b1;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        if (retire) begin
            next_state = go ? S_IF : S_IDLE;
        end
    end

    assign instr_done = retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt <= '0;
        end else if (retire) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dlx_seq_ctrl.sv
// ============================================================================
// tb_dlx_seq_ctrl : directed self-checking bench for dlx_seq_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dlx_seq_ctrl;

    localparam logic [31:0] I_ADD  = 32'h0022_1820;
    localparam logic [31:0] I_SUB  = 32'h0022_1822;
    localparam logic [31:0] I_LW   = 32'h8C22_0004;
    localparam logic [31:0] I_SW   = 32'hAC22_0004;
    localparam logic [31:0] I_BEQZ = 32'h1020_0010;
    localparam logic [31:0] I_BNEZ = 32'h1420_0010;
    localparam logic [31:0] I_J    = 32'h0800_0010;
    localparam logic [31:0] I_JAL  = 32'h0C00_0010;
    localparam logic [31:0] I_ADDI = 32'h2022_0005;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;

    // Bit positions inside the packed output vector
    localparam logic [18:0] MREQ = 19'b1 << 18;
    localparam logic [18:0] MWE  = 19'b1 << 17;
    localparam logic [18:0] ASEL = 19'b1 << 16;
    localparam logic [18:0] IRWE = 19'b1 << 15;
    localparam logic [18:0] PCWE = 19'b1 << 14;
    localparam logic [18:0] RWE  = 19'b1 << 13;
    localparam logic [18:0] WBS  = 19'b1 << 12;
    localparam logic [18:0] LNK  = 19'b1 << 11;
    localparam logic [18:0] S1   = 19'b1 << 10;
    localparam logic [18:0] DONE = 19'b1 << 1;
    localparam logic [18:0] ILL  = 19'b1;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        go        = 1'b0;
    logic        Zflag     = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] ir        = 32'h0;

    logic        mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, wb_sel, link, s1_sel;
    logic [4:0]  ALUop;
    logic [2:0]  s2op;
    logic        instr_done, illegal;
    logic [15:0] instr_cnt;

    logic        mem_req4, mem_we4, addr_sel4, ir_we4, pc_we4, reg_we4, wb_sel4, link4, s1_sel4;
    logic [4:0]  ALUop4;
    logic [2:0]  s2op4;
    logic        instr_done4, illegal4;
    logic [3:0]  instr_cnt4;

    logic [18:0] outs, outs4;
    int          n_cmp = 0;
    int          n_err = 0;
    int          mq    = 0;

    assign outs  = {mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, wb_sel, link, s1_sel,
                    ALUop, s2op, instr_done, illegal};
    assign outs4 = {mem_req4, mem_we4, addr_sel4, ir_we4, pc_we4, reg_we4, wb_sel4, link4, s1_sel4,
                    ALUop4, s2op4, instr_done4, illegal4};

    dlx_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .go(go), .ir(ir), .Zflag(Zflag), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .reg_we(reg_we), .wb_sel(wb_sel), .link(link), .s1_sel(s1_sel),
        .ALUop(ALUop), .s2op(s2op), .instr_done(instr_done), .illegal(illegal),
        .instr_cnt(instr_cnt)
    );

    dlx_seq_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .go(go), .ir(ir), .Zflag(Zflag), .mem_ready(mem_ready),
        .mem_req(mem_req4), .mem_we(mem_we4), .addr_sel(addr_sel4), .ir_we(ir_we4),
        .pc_we(pc_we4), .reg_we(reg_we4), .wb_sel(wb_sel4), .link(link4), .s1_sel(s1_sel4),
        .ALUop(ALUop4), .s2op(s2op4), .instr_done(instr_done4), .illegal(illegal4),
        .instr_cnt(instr_cnt4)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] aop(input logic [4:0] v);
        return {9'b0, v, 5'b0};
    endfunction

    function automatic logic [18:0] s2(input logic [2:0] v);
        return {14'b0, v, 2'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then drive the inputs for the new cycle and let outputs settle
    task automatic step(input logic [31:0] i, input logic g, input logic mr, input logic z);
        @(posedge clk);
        #1;
        ir        = i;
        go        = g;
        mem_ready = mr;
        Zflag     = z;
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_outs", 32'(outs), 32'h0);
        chk("rst_cnt", 32'(instr_cnt), 32'h0);
        rst_n = 1'b1;

        step(I_ADD, 0, 0, 0); chk("idle_hold", 32'(outs), 32'h0);
        step(I_ADD, 1, 0, 0); chk("idle_go", 32'(outs), 32'h0);
        step(I_ADD, 1, 1, 0); chk("add_if", 32'(outs), 32'(MREQ | IRWE));
        step(I_ADD, 1, 0, 0); chk("add_id", 32'(outs), 32'(S1 | PCWE | s2(3'b111)));
        step(I_ADD, 1, 0, 0); chk("add_ex", 32'(outs), 32'h0);
        step(I_ADD, 0, 0, 0); chk("add_wb", 32'(outs), 32'(RWE | DONE));
        step(I_LW, 1, 0, 0);  chk("add_idle", 32'(outs), 32'h0);
        chk("add_cnt", 32'(instr_cnt), 32'd1);

        for (int i = 0; i < 4; i++) begin
            step(I_LW, 1, (i == 3), 0);
            chk("lw_if", 32'(outs), 32'(MREQ | ((i == 3) ? IRWE : 19'b0)));
            mq += int'(mem_req);
        end
        step(I_LW, 1, 1, 0); chk("lw_id", 32'(outs), 32'(S1 | PCWE | s2(3'b111)));
        mq += int'(mem_req);
        step(I_LW, 1, 0, 0); chk("lw_ex", 32'(outs), 32'(s2(3'b011)));
        for (int i = 0; i < 4; i++) begin
            step(I_LW, 1, (i == 3), 0);
            chk("lw_mem", 32'(outs), 32'(MREQ | ASEL | s2(3'b011)));
            mq += int'(mem_req);
        end
        step(I_LW, 1, 0, 0); chk("lw_wb", 32'(outs), 32'(RWE | WBS | DONE));
        chk("lw_mreq_cycles", 32'(mq), 32'd8);

        step(I_BEQZ, 1, 1, 0); chk("beqz_t_if", 32'(outs), 32'(MREQ | IRWE));
        chk("lw_cnt", 32'(instr_cnt), 32'd2);
        step(I_BEQZ, 1, 0, 0);
        step(I_BEQZ, 1, 0, 1); chk("beqz_t_ex", 32'(outs), 32'(aop(5'b00010)));
        step(I_BEQZ, 1, 0, 0); chk("beqz_t_br", 32'(outs), 32'(S1 | PCWE | s2(3'b011) | DONE));

        step(I_BEQZ, 1, 1, 0); chk("beqz_t_cnt", 32'(instr_cnt), 32'd3);
        step(I_BEQZ, 1, 0, 0);
        step(I_BEQZ, 1, 0, 0); chk("beqz_nt_ex", 32'(outs), 32'(aop(5'b00010) | DONE));
        step(I_BNEZ, 1, 1, 0); chk("beqz_nt_next", 32'(outs), 32'(MREQ | IRWE));
        chk("beqz_nt_cnt", 32'(instr_cnt), 32'd4);

        step(I_BNEZ, 1, 0, 0);
        step(I_BNEZ, 1, 0, 0); chk("bnez_t_ex", 32'(outs), 32'(aop(5'b00010)));
        step(I_BNEZ, 1, 0, 0); chk("bnez_t_br", 32'(outs), 32'(S1 | PCWE | s2(3'b011) | DONE));

        step(I_J, 1, 1, 0); chk("bnez_cnt", 32'(instr_cnt), 32'd5);
        step(I_J, 1, 0, 0);
        step(I_J, 1, 0, 0); chk("j_ex", 32'(outs), 32'(S1 | s2(3'b101) | PCWE | DONE));

        step(I_JAL, 1, 1, 0); chk("j_cnt", 32'(instr_cnt), 32'd6);
        step(I_JAL, 1, 0, 0);
        step(I_JAL, 1, 0, 0); chk("jal_ex", 32'(outs), 32'(S1 | aop(5'b00010) | RWE | LNK));
        step(I_JAL, 1, 0, 0); chk("jal_br", 32'(outs), 32'(S1 | PCWE | s2(3'b101) | DONE));

        step(I_ADDI, 1, 1, 0); chk("jal_cnt", 32'(instr_cnt), 32'd7);
        step(I_ADDI, 1, 0, 0);
        step(I_ADDI, 1, 0, 0); chk("addi_ex", 32'(outs), 32'(s2(3'b011)));
        step(I_ADDI, 1, 0, 0); chk("addi_wb", 32'(outs), 32'(RWE | DONE));

        step(I_SW, 1, 1, 0); chk("addi_cnt", 32'(instr_cnt), 32'd8);
        step(I_SW, 1, 0, 0);
        step(I_SW, 1, 0, 0); chk("sw_ex", 32'(outs), 32'(s2(3'b011)));
        step(I_SW, 1, 0, 0); chk("sw_mem_wait", 32'(outs), 32'(MREQ | MWE | ASEL | s2(3'b011)));
        step(I_SW, 1, 1, 0); chk("sw_mem_rdy", 32'(outs), 32'(MREQ | MWE | ASEL | s2(3'b011) | DONE));

        step(I_BAD, 1, 1, 0); chk("sw_cnt", 32'(instr_cnt), 32'd9);
        step(I_BAD, 1, 0, 0); chk("bad_id", 32'(outs), 32'(S1 | PCWE | s2(3'b111)));
        step(I_BAD, 0, 0, 0); chk("bad_ex", 32'(outs), 32'(ILL | DONE));
        step(I_SUB, 0, 0, 0); chk("bad_idle", 32'(outs), 32'h0);
        chk("bad_cnt", 32'(instr_cnt), 32'd10);

        step(I_SUB, 1, 0, 0); chk("idle_wait", 32'(outs), 32'h0);
        step(I_SUB, 0, 1, 0); chk("sub_if", 32'(outs), 32'(MREQ | IRWE));
        step(I_SUB, 0, 0, 0);
        step(I_SUB, 0, 0, 0); chk("sub_ex", 32'(outs), 32'(aop(5'b00010)));
        step(I_SUB, 0, 0, 0); chk("sub_wb", 32'(outs), 32'(RWE | DONE));
        step(I_SUB, 0, 0, 0); chk("godrop_idle", 32'(outs), 32'h0);
        chk("sub_cnt", 32'(instr_cnt), 32'd11);
        step(I_SUB, 0, 0, 0); chk("godrop_stay", 32'(outs), 32'h0);

        step(I_BAD, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(I_BAD, 1, 1, 0);
            step(I_BAD, 1, 0, 0);
            step(I_BAD, (k < 4), 0, 0);
            chk("wrap_ex", 32'(outs4), 32'(ILL | DONE));
        end
        chk("wrap_pre4", 32'(instr_cnt4), 32'd15);
        step(I_SW, 0, 0, 0);
        chk("wrap_cnt4", 32'(instr_cnt4), 32'd0);
        chk("wrap_cnt16", 32'(instr_cnt), 32'd16);

        step(I_SW, 1, 0, 0);
        step(I_SW, 1, 1, 0);
        step(I_SW, 1, 0, 0);
        step(I_SW, 1, 0, 0);
        step(I_SW, 1, 0, 0); chk("rst_sw_mem", 32'(outs), 32'(MREQ | MWE | ASEL | s2(3'b011)));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", 32'(outs), 32'h0);
        chk("rst_mid_cnt", 32'(instr_cnt), 32'h0);
        chk("rst_mid_cnt4", 32'(instr_cnt4), 32'h0);
        step(I_SW, 0, 1, 0);
        rst_n = 1'b1;
        step(I_SW, 0, 1, 0); chk("rst_after_idle", 32'(outs), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
